// File: rtl/shutter_capture.sv
// Camera-side capture: shutter edge -> exposure wait -> NPIX-pixel stream sum -> skip/frame_done/err pulse.
// Latency: last accepted pixel at cycle N gives its skip/frame_done pulse at N+2; pix_ready is the only backpressure.
module shutter_capture #(
    parameter int PIX_W   = 8,
    parameter int NPIX    = 4,
    parameter int EXP_CYC = 2,
    parameter int TIMEOUT = 15,
    localparam int SUM_W  = PIX_W + $clog2(NPIX)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shutter,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic [SUM_W-1:0] thresh,
    output logic             pix_ready,
    output logic             skip,
    output logic             frame_done,
    output logic [SUM_W-1:0] frame_sum,
    output logic [7:0]       frame_cnt,
    output logic             missed,
    output logic             err,
    output logic             busy
);
    localparam int CNT_W = $clog2(NPIX);
    localparam int IDL_W = $clog2(TIMEOUT + 1);
    localparam int EXP_W = (EXP_CYC > 1) ? $clog2(EXP_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [IDL_W-1:0] IDLE_LIM = IDL_W'(TIMEOUT - 1);
    localparam logic [EXP_W-1:0] EXP_LOAD = EXP_W'(EXP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPOSE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_EVAL    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               shutter_q;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [IDL_W-1:0]   idle_q, idle_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               rdy_q, rdy_d;
    logic               skip_q, skip_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               missed_q, missed_d;
    logic               busy_q, busy_d;
    logic               rise;

    assign rise = shutter & ~shutter_q;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        pcnt_d   = pcnt_q;
        idle_d   = idle_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        skip_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        missed_d = missed_q | (rise & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_EXPOSE;
                    exp_d   = EXP_LOAD;
                    acc_d   = '0;
                    pcnt_d  = '0;
                    idle_d  = '0;
                end
            end
            S_EXPOSE: begin
                if (exp_q == '0) state_d = S_CAPTURE;
                else             exp_d   = exp_q - 1'b1;
            end
            S_CAPTURE: begin
                if (pix_valid && rdy_q) begin
                    acc_d  = acc_q + SUM_W'(pix_data);
                    pcnt_d = pcnt_q + 1'b1;
                    idle_d = '0;
                    if (pcnt_q == LAST_PIX) state_d = S_EVAL;
                end else if (idle_q == IDLE_LIM) begin
                    // TIMEOUT-th consecutive empty cycle: abandon the frame
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (acc_q < thresh) begin
                    skip_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    sum_d  = acc_q;
                    cnt_d  = cnt_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                missed_d = missed_q;
            end
        endcase
        rdy_d  = (state_d == S_CAPTURE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shutter_q <= 1'b0;
            exp_q     <= '0;
            pcnt_q    <= '0;
            idle_q    <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            skip_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            missed_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shutter_q <= shutter;
            exp_q     <= exp_d;
            pcnt_q    <= pcnt_d;
            idle_q    <= idle_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            skip_q    <= skip_d;
            done_q    <= done_d;
            err_q     <= err_d;
            missed_q  <= missed_d;
            busy_q    <= busy_d;
        end
    end

    assign pix_ready  = rdy_q;
    assign skip       = skip_q;
    assign frame_done = done_q;
    assign frame_sum  = sum_q;
    assign frame_cnt  = cnt_q;
    assign missed     = missed_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shutter_capture.sv
// Randomized bench for shutter_capture against a frame-level reference model.
module tb_shutter_capture;
    localparam int PIX_W   = 8;
    localparam int NPIX    = 4;
    localparam int EXP_CYC = 2;
    localparam int TIMEOUT = 15;
    localparam int SUM_W   = PIX_W + $clog2(NPIX);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             shutter;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic [SUM_W-1:0] thresh;
    logic             pix_ready;
    logic             skip;
    logic             frame_done;
    logic [SUM_W-1:0] frame_sum;
    logic [7:0]       frame_cnt;
    logic             missed;
    logic             err;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int exp_cnt    = 0;
    int exp_sum    = 0;
    bit exp_missed = 1'b0;

    int px[NPIX];
    int gp[NPIX];

    shutter_capture #(
        .PIX_W(PIX_W), .NPIX(NPIX), .EXP_CYC(EXP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .shutter(shutter),
        .pix_valid(pix_valid), .pix_data(pix_data), .thresh(thresh),
        .pix_ready(pix_ready), .skip(skip), .frame_done(frame_done),
        .frame_sum(frame_sum), .frame_cnt(frame_cnt), .missed(missed),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rdy"},  32'(pix_ready), 0);
        chk({tag, ".skip"}, 32'(skip), 0);
        chk({tag, ".done"}, 32'(frame_done), 0);
        chk({tag, ".sum"},  32'(frame_sum), 0);
        chk({tag, ".cnt"},  32'(frame_cnt), 0);
        chk({tag, ".miss"}, 32'(missed), 0);
        chk({tag, ".err"},  32'(err), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // One frame: shutter rise, exposure, px[] streamed with gp[] idle cycles before each pixel.
    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_frame(input int th, input bit poke);
        int  sv[$];
        int  sd[$];
        int  acc;
        int  idle;
        bit  aborted;
        for (int i = 0; i < NPIX; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                sv.push_back(0);
                sd.push_back(int'($urandom_range(0, 255)));
            end
            sv.push_back(1);
            sd.push_back(px[i]);
        end
        thresh = SUM_W'(th);
        @(negedge clk);
        shutter = 1'b1;
        @(negedge clk);
        shutter = 1'b0;
        for (int i = 0; i < EXP_CYC; i++) begin
            chk("exp.rdy", 32'(pix_ready), 0);
            chk("exp.busy", 32'(busy), 1);
            if (poke && i == EXP_CYC - 1) shutter = 1'b1;
            @(negedge clk);
        end
        if (poke) exp_missed = 1'b1;
        acc = 0;
        idle = 0;
        aborted = 1'b0;
        for (int k = 0; k < sv.size(); k++) begin
            chk("cap.rdy", 32'(pix_ready), 1);
            pix_valid = sv[k][0];
            pix_data  = PIX_W'(sd[k]);
            shutter   = poke && (k == 1);
            @(posedge clk);
            if (sv[k] != 0) begin
                acc += sd[k];
                idle = 0;
            end else begin
                idle++;
            end
            @(negedge clk);
            if (idle == TIMEOUT) begin
                aborted = 1'b1;
                break;
            end
        end
        pix_valid = 1'b0;
        shutter   = 1'b0;
        if (aborted) begin
            chk("to.err", 32'(err), 1);
            chk("to.busy", 32'(busy), 0);
            chk("to.rdy", 32'(pix_ready), 0);
            chk("to.skip", 32'(skip), 0);
            chk("to.done", 32'(frame_done), 0);
            chk("to.cnt", 32'(frame_cnt), 32'(exp_cnt));
            chk("to.sum", 32'(frame_sum), 32'(exp_sum));
        end else begin
            chk("eval.rdy", 32'(pix_ready), 0);
            chk("eval.busy", 32'(busy), 1);
            chk("eval.pulse", 32'({skip, frame_done, err}), 0);
            @(negedge clk);
            if (acc < th) begin
                chk("fr.skip", 32'(skip), 1);
                chk("fr.done", 32'(frame_done), 0);
            end else begin
                exp_sum = acc;
                exp_cnt = (exp_cnt + 1) % 256;
                chk("fr.skip", 32'(skip), 0);
                chk("fr.done", 32'(frame_done), 1);
            end
            chk("fr.err", 32'(err), 0);
            chk("fr.sum", 32'(frame_sum), 32'(exp_sum));
            chk("fr.cnt", 32'(frame_cnt), 32'(exp_cnt));
            chk("fr.busy", 32'(busy), 0);
        end
        chk("miss", 32'(missed), 32'(exp_missed));
        @(negedge clk);
        chk("post.pulse", 32'({skip, frame_done, err}), 0);
        chk("post.busy", 32'(busy), 0);
        chk("post.rdy", 32'(pix_ready), 0);
    endtask

    task automatic set_px(input int a, input int b, input int c, input int d);
        px[0] = a; px[1] = b; px[2] = c; px[3] = d;
    endtask

    task automatic set_gp(input int a, input int b, input int c, input int d);
        gp[0] = a; gp[1] = b; gp[2] = c; gp[3] = d;
    endtask

    initial begin
        int r;
        int tot;
        int th;
        reset_n   = 1'b0;
        shutter   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        thresh    = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;

        // reset in the middle of CAPTURE after one accepted pixel
        @(negedge clk);
        shutter = 1'b1;
        repeat (1 + EXP_CYC) @(negedge clk);
        shutter = 1'b0;
        chk("mid.rdy", 32'(pix_ready), 1);
        pix_valid = 1'b1;
        pix_data  = 8'd77;
        @(negedge clk);
        pix_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.rdy", 32'(pix_ready), 0);
            chk("idle.busy", 32'(busy), 0);
        end

        // directed frames
        set_px(10, 20, 30, 40); set_gp(0, 0, 0, 0);
        run_frame(50, 1'b0);
        run_frame(200, 1'b0);
        run_frame(100, 1'b0);
        set_gp(3, 3, 3, 3);
        run_frame(0, 1'b0);
        set_gp(0, 0, TIMEOUT - 1, 0);
        run_frame(0, 1'b0);
        set_gp(0, 0, TIMEOUT, 0);
        run_frame(0, 1'b0);
        set_gp(0, 1, 0, 2);
        run_frame(60, 1'b1);

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            tot = 0;
            for (int i = 0; i < NPIX; i++) begin
                px[i] = int'($urandom_range(0, 255));
                tot += px[i];
                r = int'($urandom_range(0, 19));
                if (r < 12)       gp[i] = 0;
                else if (r < 16)  gp[i] = int'($urandom_range(1, 4));
                else if (r == 16) gp[i] = TIMEOUT - 1;
                else if (r == 17) gp[i] = TIMEOUT;
                else              gp[i] = TIMEOUT + int'($urandom_range(1, 5));
                if (r >= 16 && $urandom_range(0, 1) == 0) gp[i] = 0;
            end
            r = int'($urandom_range(0, 3));
            if (r == 0)      th = tot;
            else if (r == 1) th = tot + 1;
            else             th = int'($urandom_range(0, 1023));
            run_frame(th, $urandom_range(0, 7) == 0);
        end

        // counter wrap with full-scale pixels
        set_px(255, 255, 255, 255); set_gp(0, 0, 0, 0);
        for (int f = 0; f < 256; f++) run_frame(1020, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/shutter_capture.md
Name: shutter_capture

Overview:
- Camera-side partner of the shutter/skip capture controller.
- Detects each shutter rising edge, waits out a fixed exposure delay, then accepts one frame of pixels over a valid/ready stream and accumulates their sum.
- Judges the frame against a threshold and returns a one-cycle skip pulse (dark frame) or a frame_done pulse with the frame sum.
- Sits between the controller's shutter output/skip input and the pixel source.

Parameters:
PIX_W, 8, pixel data width
NPIX, 4, pixels per frame (power of two, >=2)
EXP_CYC, 2, exposure delay in cycles after shutter rise (>=1)
TIMEOUT, 15, max consecutive CAPTURE cycles without an accepted pixel before abort
SUM_W (local), PIX_W+log2(NPIX), accumulator/result width

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
shutter  input  1  shutter level from controller; rising edge triggers capture
pix_valid  input  1  pixel source has data
pix_data  input  PIX_W  pixel value
thresh  input  SUM_W  skip threshold, sampled in EVAL
pix_ready  output  1  block accepts a pixel this cycle
skip  output  1  one-cycle pulse: frame below threshold
frame_done  output  1  one-cycle pulse: frame accepted
frame_sum  output  SUM_W  sum of last accepted frame
frame_cnt  output  8  count of accepted frames, wraps 255->0
missed  output  1  sticky: shutter rise arrived while busy
err  output  1  one-cycle pulse: capture timeout abort
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (reset_n=0, async): state=IDLE; all outputs 0; shutter_d=0; accumulator=0; counters=0.
- Reset mid-frame discards the partial frame; no skip, frame_done or err pulse is issued.
- Edge detect: rise = shutter & ~shutter_d, where shutter_d is registered every cycle.
- IDLE, on rise:
  - go to EXPOSE; exposure counter = EXP_CYC-1.
  - accumulator cleared; pixel counter cleared.
- Rise outside IDLE: sets missed=1 (sticky until reset); the current operation is unaffected.
- EXPOSE: counter decrements each cycle; at 0 go to CAPTURE. Exactly EXP_CYC cycles are spent in EXPOSE.
- CAPTURE:
  - pix_ready=1 for every cycle in CAPTURE, 0 in all other states.
  - Accept happens when pix_valid & pix_ready: accumulator += pix_data (zero-extended to SUM_W, cannot overflow); pixel counter += 1; idle counter cleared.
  - If no accept this cycle, idle counter += 1.
  - On the accept that brings the pixel count to NPIX, go to EVAL; pix_ready is 0 from the next cycle on.
  - Idle counter reaching TIMEOUT → err pulse next cycle, go to IDLE; frame_sum and frame_cnt unchanged.
- EVAL (one cycle):
  - If accumulator < thresh (unsigned): skip=1 next cycle.
  - Otherwise frame_done=1 next cycle, frame_sum=accumulator, frame_cnt+=1 with modulo-256 wrap.
  - Go to IDLE.
  - Equality (sum == thresh) counts as accepted.
- Pulses: skip, frame_done and err are each high for exactly one cycle and are mutually exclusive.
- Latency: last accepted pixel at cycle N → skip or frame_done high at cycle N+2.
- Back-to-back frames: a rise in the same cycle the skip/frame_done pulse is driven (state now IDLE) is accepted normally.
- Unknown state encoding → IDLE, with outputs as at reset except missed, frame_sum and frame_cnt, which hold.

Test Plan:
- Reset: assert reset_n=0 mid-CAPTURE → all outputs 0 immediately; release → IDLE; pix_ready=0 until next shutter rise plus 2 cycles.
- Accepted frame: rise; pixels 10,20,30,40 streamed back-to-back; thresh=50 → pix_ready high exactly 4 cycles; frame_done one cycle 2 cycles after last pixel; frame_sum=100; frame_cnt=1; skip=0.
- Dark frame: same pixels, thresh=200 → skip one-cycle pulse; frame_done=0; frame_sum stays 100; frame_cnt unchanged. Also thresh=100 → frame_done (equality boundary).
- Stalls and timeout: pix_valid gaps of 3 cycles between pixels → sum correct, no err. Then a frame with 15 idle cycles after the 2nd pixel → err pulse, back to IDLE, frame_cnt unchanged.
- Missed shutter: rise during EXPOSE and another during CAPTURE → missed=1 and stays 1; the current frame completes normally; no second capture starts.
- Wrap: 256 accepted frames → frame_cnt goes 255→0; pixels 255,255,255,255 → frame_sum=1020 (full-width, no overflow).
